// File: rtl/eth_recv_ts.sv
// -----------------------------------------------------------------------------
// eth_recv_ts
//
// Receive-side timestamp probe parser for a 10G MAC RX stream (64-bit beats).
// Each frame is stamped with the local time of its first beat. Frames whose
// ethertype (bytes 12..13) matches ETHERTYPE are probes: the TX timestamp
// (bytes 16..23, big-endian) and sequence number (bytes 24..27, big-endian)
// are extracted. When a good probe ends, the one-entry result register is
// loaded with the sequence number and the one-way latency (rx - tx, mod 2^64).
//
// Ports
//   clk156            in   MAC core clock, only clock of the block
//   reset_n           in   asynchronous active-low reset
//   s_axis_rx_tdata   in   64-bit RX beat, byte n on bits [8n+7:8n]
//   s_axis_rx_tkeep   in   byte enables (not used for parsing)
//   s_axis_rx_tvalid  in   beat valid, no back-pressure
//   s_axis_rx_tlast   in   last beat of the frame
//   s_axis_rx_tuser   in   frame-good flag, meaningful on the tlast beat
//   ts_now            out  free-running local time in clk156 cycles
//   res_valid         out  result register holds an entry
//   res_ready         in   result consumed when res_valid & res_ready
//   res_seq           out  probe sequence number
//   res_latency       out  rx_ts - tx_ts, modulo 2^64
//   cnt_ok/bad/drop   out  saturating statistics counters
// -----------------------------------------------------------------------------
module eth_recv_ts #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          CNT_W     = 32
) (
  input  logic             clk156,
  input  logic             reset_n,
  input  logic [63:0]      s_axis_rx_tdata,
  input  logic [7:0]       s_axis_rx_tkeep,
  input  logic             s_axis_rx_tvalid,
  input  logic             s_axis_rx_tlast,
  input  logic             s_axis_rx_tuser,
  output logic [63:0]      ts_now,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_seq,
  output logic [63:0]      res_latency,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_drop
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    TS   = 3'd2,
    SEQ  = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [63:0] rx_ts;
  logic [63:0] tx_ts;
  logic [31:0] seq;
  logic        is_probe;

  logic [15:0] etype_p0;
  logic        etype_hit_p0;
  logic [63:0] tx_beat_p0;
  logic [31:0] seq_beat_p0;
  logic        frame_end_p0;
  logic        probe_known_p0;
  logic        seq_done_p0;
  logic        good_p0;
  logic        bad_p0;
  logic [31:0] seq_p0;
  logic [63:0] lat_p0;
  logic        load_p0;

  // Byte enables carry no information the parser needs: fields sit at fixed
  // byte offsets regardless of tkeep.
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_rx_tkeep;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  // Lowest-addressed byte of the beat becomes the most significant byte.
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) begin
      r[63-8*k -: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[31-8*k -: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: beat decode and frame classification (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    etype_p0     = {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
    etype_hit_p0 = (etype_p0 == ETHERTYPE);
    tx_beat_p0   = bswap64(s_axis_rx_tdata);
    seq_beat_p0  = bswap32(s_axis_rx_tdata[31:0]);
    frame_end_p0 = s_axis_rx_tvalid & s_axis_rx_tlast;

    // probe_known: the frame is already identified as a probe.
    // seq_done: the sequence beat has been (or is being) consumed.
    // A frame ending in IDLE never showed its ethertype, so it is not a probe.
    probe_known_p0 = 1'b0;
    seq_done_p0    = 1'b0;
    unique case (state)
      IDLE: begin
        probe_known_p0 = 1'b0;
        seq_done_p0    = 1'b0;
      end
      HDR: begin
        probe_known_p0 = etype_hit_p0;
        seq_done_p0    = 1'b0;
      end
      TS: begin
        probe_known_p0 = 1'b1;
        seq_done_p0    = 1'b0;
      end
      SEQ: begin
        probe_known_p0 = 1'b1;
        seq_done_p0    = 1'b1;
      end
      WAIT: begin
        probe_known_p0 = is_probe;
        seq_done_p0    = is_probe;
      end
      default: begin
        probe_known_p0 = 1'b0;
        seq_done_p0    = 1'b0;
      end
    endcase

    bad_p0  = frame_end_p0 & (~s_axis_rx_tuser | (probe_known_p0 & ~seq_done_p0));
    good_p0 = frame_end_p0 & s_axis_rx_tuser & probe_known_p0 & seq_done_p0;

    // When tlast lands on the sequence beat itself the field is still on the bus.
    seq_p0  = (state == SEQ) ? seq_beat_p0 : seq;
    lat_p0  = rx_ts - tx_ts;
    load_p0 = good_p0 & (~res_valid | res_ready);
  end

  always_comb begin
    state_nxt = state;
    if (s_axis_rx_tvalid) begin
      if (s_axis_rx_tlast) begin
        state_nxt = IDLE;
      end else begin
        unique case (state)
          IDLE:    state_nxt = HDR;
          HDR:     state_nxt = etype_hit_p0 ? TS : WAIT;
          TS:      state_nxt = SEQ;
          SEQ:     state_nxt = WAIT;
          WAIT:    state_nxt = WAIT;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ts_now   <= '0;
      rx_ts    <= '0;
      tx_ts    <= '0;
      seq      <= '0;
      is_probe <= 1'b0;
    end else begin
      state  <= state_nxt;
      ts_now <= ts_now + 64'd1;
      if (s_axis_rx_tvalid) begin
        unique case (state)
          IDLE: begin
            rx_ts    <= ts_now;
            is_probe <= 1'b0;
          end
          HDR:     is_probe <= etype_hit_p0;
          TS:      tx_ts    <= tx_beat_p0;
          SEQ:     seq      <= seq_beat_p0;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: one-entry result register and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      res_valid   <= 1'b0;
      res_seq     <= '0;
      res_latency <= '0;
      cnt_ok      <= '0;
      cnt_bad     <= '0;
      cnt_drop    <= '0;
    end else begin
      if (load_p0) begin
        res_valid   <= 1'b1;
        res_seq     <= seq_p0;
        res_latency <= lat_p0;
      end else if (res_ready) begin
        res_valid   <= 1'b0;
      end

      if (load_p0) begin
        cnt_ok <= sat_inc(cnt_ok);
      end
      if (good_p0 && !load_p0) begin
        cnt_drop <= sat_inc(cnt_drop);
      end
      if (bad_p0) begin
        cnt_bad <= sat_inc(cnt_bad);
      end
    end
  end

endmodule
